// File: rtl/lane_sched_pkg.sv
// Shared constants for the lane scheduler: state encoding and default sizing.
package lane_sched_pkg;

  localparam int unsigned DEFAULT_DATA_W  = 32;
  localparam int unsigned DEFAULT_CREDITS = 4;

  // The state doubles as the next-lane pointer once out of INIT.
  localparam logic [1:0] ST_INIT  = 2'd0;
  localparam logic [1:0] ST_LANE0 = 2'd1;
  localparam logic [1:0] ST_LANE1 = 2'd2;

endpackage

// File: rtl/lane_credit_counter.sv
// Per-lane credit counter mirroring the downstream buffer occupancy.
// Starts full (CREDITS), decrements on issue, increments on return.
module lane_credit_counter
  import lane_sched_pkg::*;
#(
  parameter int unsigned CREDITS = DEFAULT_CREDITS
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           issue,
  input  logic                           ret,
  output logic [$clog2(CREDITS + 1)-1:0] count,
  output logic                           has_credit,
  output logic                           overflow
);

  localparam int unsigned CW = $clog2(CREDITS + 1);
  localparam logic [CW-1:0] FULL = CW'(CREDITS);

  logic [CW-1:0] count_q, count_d;

  // Next count: simultaneous issue and return cancel; a return at full saturates.
  always_comb begin
    count_d  = count_q;
    overflow = 1'b0;
    if (issue && !ret) begin
      count_d = count_q - CW'(1);
    end else if (ret && !issue) begin
      if (count_q == FULL) begin
        overflow = 1'b1;
      end else begin
        count_d = count_q + CW'(1);
      end
    end
  end

  // Counter register, re-initialised to full on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= FULL;
    end else begin
      count_q <= count_d;
    end
  end

  assign count      = count_q;
  assign has_credit = (count_q != '0);

endmodule

// File: rtl/lane_scheduler.sv
// Two-lane scheduler: deals an incoming word stream strictly alternately to
// lane 0 and lane 1, gated by per-lane credits. Never skips a lane.
// Optional feature: LANE_SCHED_FLUSH_EN adds a flush input that realigns the
// lane pointer to lane 0.
module lane_scheduler
  import lane_sched_pkg::*;
#(
  parameter int unsigned DATA_W  = DEFAULT_DATA_W,
  parameter int unsigned CREDITS = DEFAULT_CREDITS
) (
  input  logic                           clk,
  input  logic                           reset,
`ifdef LANE_SCHED_FLUSH_EN
  input  logic                           flush,
`endif
  input  logic                           valid_in,
  input  logic [DATA_W-1:0]              data_in,
  output logic                           ready_out,
  input  logic                           credit_ret_0,
  input  logic                           credit_ret_1,
  output logic                           valid_0,
  output logic [DATA_W-1:0]              lane_0,
  output logic                           valid_1,
  output logic [DATA_W-1:0]              lane_1,
  output logic [$clog2(CREDITS + 1)-1:0] credit_0,
  output logic [$clog2(CREDITS + 1)-1:0] credit_1,
  output logic                           err_credit
);

  logic [1:0]        state_q, state_d;
  logic              valid_0_q, valid_1_q;
  logic [DATA_W-1:0] lane_0_q, lane_1_q;
  logic              err_q;

  logic has_credit_0, has_credit_1;
  logic overflow_0, overflow_1;
  logic pointed_has_credit;
  logic accept, issue_0, issue_1;
  logic flush_req;

`ifdef LANE_SCHED_FLUSH_EN
  assign flush_req = flush;
`else
  assign flush_req = 1'b0;
`endif

  // Ready depends only on registered state/credits (plus flush), never on
  // same-cycle credit returns.
  assign pointed_has_credit = (state_q == ST_LANE1) ? has_credit_1 : has_credit_0;
  assign ready_out = ((state_q == ST_LANE0) || (state_q == ST_LANE1)) &&
                     pointed_has_credit && !flush_req;
  assign accept    = valid_in && ready_out;
  assign issue_0   = accept && (state_q == ST_LANE0);
  assign issue_1   = accept && (state_q == ST_LANE1);

  // Pointer FSM: INIT for one cycle, then alternate lanes on each accept.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT:  state_d = ST_LANE0;
      ST_LANE0: begin
        if (flush_req) begin
          state_d = ST_LANE0;
        end else if (accept) begin
          state_d = ST_LANE1;
        end
      end
      ST_LANE1: begin
        if (flush_req || accept) begin
          state_d = ST_LANE0;
        end
      end
      default:  state_d = ST_INIT;
    endcase
  end

  // State, lane output registers and sticky credit error.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_INIT;
      valid_0_q <= 1'b0;
      valid_1_q <= 1'b0;
      lane_0_q  <= '0;
      lane_1_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      valid_0_q <= issue_0;
      valid_1_q <= issue_1;
      if (issue_0) begin
        lane_0_q <= data_in;
      end
      if (issue_1) begin
        lane_1_q <= data_in;
      end
      err_q     <= err_q | overflow_0 | overflow_1;
    end
  end

  lane_credit_counter #(
    .CREDITS(CREDITS)
  ) u_credit_0 (
    .clk        (clk),
    .reset      (reset),
    .issue      (issue_0),
    .ret        (credit_ret_0),
    .count      (credit_0),
    .has_credit (has_credit_0),
    .overflow   (overflow_0)
  );

  lane_credit_counter #(
    .CREDITS(CREDITS)
  ) u_credit_1 (
    .clk        (clk),
    .reset      (reset),
    .issue      (issue_1),
    .ret        (credit_ret_1),
    .count      (credit_1),
    .has_credit (has_credit_1),
    .overflow   (overflow_1)
  );

  assign valid_0    = valid_0_q;
  assign valid_1    = valid_1_q;
  assign lane_0     = lane_0_q;
  assign lane_1     = lane_1_q;
  assign err_credit = err_q;

endmodule

// File: tb/tb_lane_scheduler.sv
// Self-checking bench for lane_scheduler: directed scenarios plus a random
// phase, all compared every cycle against a behavioural reference model.
module tb_lane_scheduler;
  import lane_sched_pkg::*;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned CREDITS = 4;
  localparam int unsigned CW      = $clog2(CREDITS + 1);

  logic              clk = 1'b0;
  logic              reset, valid_in, ready_out, credit_ret_0, credit_ret_1;
  logic              valid_0, valid_1, err_credit, flush;
  logic [DATA_W-1:0] data_in, lane_0, lane_1;
  logic [CW-1:0]     credit_0, credit_1;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  lane_scheduler #(
    .DATA_W  (DATA_W),
    .CREDITS (CREDITS)
  ) dut (
    .clk          (clk),
    .reset        (reset),
`ifdef LANE_SCHED_FLUSH_EN
    .flush        (flush),
`endif
    .valid_in     (valid_in),
    .data_in      (data_in),
    .ready_out    (ready_out),
    .credit_ret_0 (credit_ret_0),
    .credit_ret_1 (credit_ret_1),
    .valid_0      (valid_0),
    .lane_0       (lane_0),
    .valid_1      (valid_1),
    .lane_1       (lane_1),
    .credit_0     (credit_0),
    .credit_1     (credit_1),
    .err_credit   (err_credit)
  );

  // Reference model: next lane (-1 = just out of reset), credits, outputs.
  int                m_ptr;
  int                m_cred[2];
  bit                m_err;
  bit                m_v[2];
  logic [DATA_W-1:0] m_lane[2];
  bit                m_acc;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit m_ready(input bit fl);
    if (m_ptr < 0 || fl) return 1'b0;
    return m_cred[m_ptr] > 0;
  endfunction

  task automatic model_step(input bit v, input logic [DATA_W-1:0] d, input bit r0,
                            input bit r1, input bit rst, input bit fl);
    bit rdy;
    bit r[2];
    bit iss;
    rdy  = m_ready(fl);
    r[0] = r0;
    r[1] = r1;
    m_acc = 1'b0;
    if (rst) begin
      m_ptr   = -1;
      m_cred  = '{int'(CREDITS), int'(CREDITS)};
      m_err   = 1'b0;
      m_v     = '{1'b0, 1'b0};
      m_lane  = '{'0, '0};
      return;
    end
    m_acc = v && rdy;
    m_v   = '{1'b0, 1'b0};
    for (int l = 0; l < 2; l++) begin
      iss = m_acc && (m_ptr == l);
      if (iss) begin
        m_v[l]    = 1'b1;
        m_lane[l] = d;
      end
      if (iss && !r[l]) m_cred[l]--;
      else if (r[l] && !iss) begin
        if (m_cred[l] == int'(CREDITS)) m_err = 1'b1;
        else m_cred[l]++;
      end
    end
    if (m_ptr < 0 || fl) m_ptr = 0;
    else if (m_acc) m_ptr = 1 - m_ptr;
  endtask

  // One clock: drive at the falling edge, check ready before the rising edge,
  // check registered outputs 1 time unit after it.
  task automatic cycle(input bit v, input logic [DATA_W-1:0] d, input bit r0, input bit r1,
                       input bit rst, input bit fl);
    valid_in     = v;
    data_in      = d;
    credit_ret_0 = r0;
    credit_ret_1 = r1;
    reset        = rst;
    flush        = fl;
    #1;
    if (!rst) check_eq("ready_out", 64'(ready_out), 64'(m_ready(fl)));
    @(posedge clk);
    model_step(v, d, r0, r1, rst, fl);
    #1;
    check_eq("valid_0", 64'(valid_0), 64'(m_v[0]));
    check_eq("valid_1", 64'(valid_1), 64'(m_v[1]));
    check_eq("lane_0", 64'(lane_0), 64'(m_lane[0]));
    check_eq("lane_1", 64'(lane_1), 64'(m_lane[1]));
    check_eq("credit_0", 64'(credit_0), 64'(m_cred[0]));
    check_eq("credit_1", 64'(credit_1), 64'(m_cred[1]));
    check_eq("err_credit", 64'(err_credit), 64'(m_err));
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(1);
  endtask

  task automatic send(input logic [DATA_W-1:0] d);
    for (int i = 0; i < 32; i++) begin
      cycle(1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0);
      if (m_acc) return;
    end
    check_eq("send_timeout", 64'(m_acc), 64'd1);
  endtask

  initial begin
    logic [DATA_W-1:0] w;
    bit r0, r1, fl, rst;
    m_ptr = -1;
    m_cred = '{int'(CREDITS), int'(CREDITS)};
    flush = 1'b0;

    // Reset values.
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_eq("rst_ready", 64'(ready_out), 64'd0);
    check_eq("rst_credit_0", 64'(credit_0), 64'(CREDITS));
    idle(1);

    // A0..A5 alternate lanes, leaving one credit per lane.
    for (int i = 0; i < 6; i++) send(32'hA0 + 32'(i));
    check_eq("a_lane_1", 64'(lane_1), 64'hA5);
    check_eq("a_lane_0", 64'(lane_0), 64'hA4);
    check_eq("a_credit_0", 64'(credit_0), 64'd1);
    check_eq("a_credit_1", 64'(credit_1), 64'd1);

    // Eight accepts exhaust credits; 9th word waits for a lane 0 return.
    send(32'hA6);
    send(32'hA7);
    check_eq("b_ready_low", 64'(ready_out), 64'd0);
    cycle(1'b1, 32'hB8, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("b_held", 64'(valid_0), 64'd0);
    cycle(1'b1, 32'hB8, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'hB8, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("b_valid_0", 64'(valid_0), 64'd1);
    check_eq("b_lane_0", 64'(lane_0), 64'hB8);

    // Lane 0 empty, lane 1 full, pointer on lane 0: no skipping.
    do_reset();
    for (int i = 0; i < 8; i++) send(32'hC0 + 32'(i));
    for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("c_credit_1", 64'(credit_1), 64'd4);
    check_eq("c_ready_low", 64'(ready_out), 64'd0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'hCC, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("c_no_lane1", 64'(valid_1), 64'd0);
    cycle(1'b1, 32'hCC, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'hCC, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("c_resume_lane0", 64'(valid_0), 64'd1);

    // Issue+return cancel on lane 1; return at full sets sticky error.
    do_reset();
    send(32'hD0);
    cycle(1'b1, 32'hD1, 1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("d_credit_1", 64'(credit_1), 64'd4);
    check_eq("d_err_clear", 64'(err_credit), 64'd0);
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("d_err_set", 64'(err_credit), 64'd1);
    check_eq("d_credit_0", 64'(credit_0), 64'd4);
    idle(2);
    check_eq("d_err_sticky", 64'(err_credit), 64'd1);

    // Reset mid-stream with pointer on lane 1 and credits 2/1.
    do_reset();
    for (int i = 0; i < 7; i++) send(32'hE0 + 32'(i));
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("e_credit_0", 64'(credit_0), 64'd2);
    check_eq("e_credit_1", 64'(credit_1), 64'd1);
    cycle(1'b1, 32'hEE, 1'b0, 1'b0, 1'b1, 1'b0);
    check_eq("e_no_valid", 64'(valid_1), 64'd0);
    check_eq("e_cred_full", 64'(credit_1), 64'(CREDITS));
    idle(1);
    send(32'hEF);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("e_first_lane0", 64'(lane_0), 64'hEF);

`ifdef LANE_SCHED_FLUSH_EN
    // Flush with pointer on lane 1 blocks the accept and realigns to lane 0.
    do_reset();
    send(32'hF0);
    cycle(1'b1, 32'hF1, 1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("f_no_accept", 64'(valid_1), 64'd0);
    send(32'hF1);
    check_eq("f_lane0", 64'(lane_0), 64'hF1);
`endif

    // Random phase: returns mostly only for outstanding entries.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      w   = $urandom;
      rst = ($urandom_range(0, 79) == 0);
      r0  = ((m_cred[0] < int'(CREDITS)) && ($urandom_range(0, 2) == 0)) ||
            ($urandom_range(0, 60) == 0);
      r1  = ((m_cred[1] < int'(CREDITS)) && ($urandom_range(0, 2) == 0)) ||
            ($urandom_range(0, 60) == 0);
      fl  = 1'b0;
`ifdef LANE_SCHED_FLUSH_EN
      fl  = ($urandom_range(0, 15) == 0);
`endif
      cycle(($urandom_range(0, 3) != 0), w, r0, r1, rst, fl);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
